imem_fetch_queue: RTL
=====================

Name: imem_fetch_queue

Overview:
Parametrised instruction memory for the 5-stage pipeline's IF stage, with a decoupled fetch interface. It accepts PC requests through a valid/ready handshake and reads a word-addressed array synchronously. Results go into a 2-entry response queue with fault tagging, flush and a runtime program-load port. A delivered-instruction counter supports performance checks.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, PC width in bits
DEPTH, 128, number of instruction words (power of two, >=4)
IDX_W, $clog2(DEPTH), word index width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  program-load write strobe
load_idx  input  IDX_W  word index for load
load_data  input  DATA_W  word to write
flush  input  1  discard all queued and in-cycle requests
req_valid  input  1  PC request valid
req_ready  output  1  request can be accepted this cycle
req_pc  input  ADDR_W  byte address of instruction
rsp_valid  output  1  queue head valid
rsp_ready  input  1  consumer takes head this cycle
rsp_instr  output  DATA_W  instruction at head (0 on fault)
rsp_pc  output  ADDR_W  PC that produced head
rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range
fetch_cnt  output  32  count of responses consumed (rsp_valid&&rsp_ready)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, named rst_n.
- Reset values:
  - queue count = 0, so rsp_valid = 0.
  - rsp_instr, rsp_pc, rsp_fault and fetch_cnt all read 0.
  - req_ready = 1 once reset is released.
  - Array contents are NOT reset; every word is initialised to 0 at time zero.
- Handshake:
  - accept = req_valid && req_ready && !flush.
  - pop = rsp_valid && rsp_ready && !flush.
  - req_ready = (count != 2). It depends on registered state only; there is no combinational path from rsp_ready.
- Latency:
  - An accepted request at edge N is visible at the head after edge N if the queue was empty, so rsp_valid is high in the cycle following accept.
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - count 1: push and pop together leave count at 1 with the new entry at the head.
  - count 2: push is impossible (req_ready = 0); a pop alone takes count to 1.
- Fault decode happens at accept time:
  - req_pc[1:0] != 0 gives fault 01.
  - Otherwise, req_pc[ADDR_W-1:2] >= DEPTH gives fault 10.
  - Misaligned has priority over out of range.
  - On any fault, the stored instr is 0; pc and fault are stored as given.
  - No array access occurs for faulted requests.
- Array read: index = req_pc[IDX_W+1:2], read synchronously at the accept edge.
- Load port:
  - When load_en is high, the array[load_idx] write occurs at the edge.
  - A same-cycle accepted read to the same index returns the OLD word (read-before-write).
  - Loads are independent of flush and of the handshake.
- Flush:
  - Count goes to 0 at the next edge.
  - The same-cycle request is dropped and the same-cycle pop does not count.
  - fetch_cnt is unchanged.
  - req_ready is 1 the following cycle.
- fetch_cnt: increments by 1 per pop and wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-operation: queue contents are lost immediately (asynchronous) and outputs go to their reset values in the same cycle.
- While rsp_valid = 0, rsp_instr, rsp_pc and rsp_fault hold 0.

Test Plan:
- Load words 0..3 = 00222820, 20610006, 00823022, AC640004, then request pc=0,4,8,12 back-to-back with rsp_ready=1 -> rsp_instr appears in that order, one per cycle after a 1-cycle latency; fetch_cnt=4.
- rsp_ready=0 while requesting pc=0,4,8 -> third request stalls (req_ready=0 after 2 accepts). Then raise rsp_ready -> 00222820 and 20610006 drain, then pc=8 is accepted and returns 00823022.
- req_pc=0x6 -> fault 01, instr 0. req_pc=0x200 with DEPTH=128 -> fault 10, instr 0. req_pc=0x202 -> fault 01.
- Same cycle: load_en with idx 1 = DEADBEEF and accepted read of pc=4 -> returns 20610006; the next read of pc=4 returns DEADBEEF.
- Queue holds 2 entries while flush is asserted together with req_valid and rsp_ready -> next cycle rsp_valid=0, req_ready=1, fetch_cnt unchanged, and the dropped request never appears.
- Pull rst_n low mid-stream with count=2 -> rsp_valid=0 and fetch_cnt=0 immediately, without waiting for a clock edge. After release, previously loaded array words still read back intact.

Source files
------------

// File: rtl/imem_fetch_queue.sv
// Word-addressed instruction memory behind a valid/ready fetch port, with a
// 2-entry response queue carrying fault tags, flush, program load and a pop counter.
module imem_fetch_queue #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 128,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic [1:0]        rsp_fault,
    output logic [31:0]       fetch_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        fault;
    } entry_t;

    // Array is never reset; it starts at zero and is only changed by the load port.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    logic [1:0]  r_count;
    entry_t      r_q0;
    entry_t      r_q1;
    logic [31:0] r_fetch_cnt;

    logic             w_accept;
    logic             w_pop;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_fault;
    entry_t           w_new;

    assign req_ready = (r_count != 2'd2);
    assign rsp_valid = (r_count != 2'd0);
    assign w_accept  = req_valid && req_ready && !flush;
    assign w_pop     = rsp_valid && rsp_ready && !flush;
    assign w_idx     = req_pc[IDX_W+1:2];

    always_comb begin
        w_fault = 2'b00;
        if (req_pc[1:0] != 2'b00)
            w_fault = 2'b01;
        else if ((req_pc >> 2) >= ADDR_W'(DEPTH))
            w_fault = 2'b10;
    end

    // The read is sampled into the queue at the accept edge while the load write
    // lands at the same edge, so a same-index read observes the old word.
    always_comb begin
        w_new.pc    = req_pc;
        w_new.fault = w_fault;
        w_new.instr = '0;
        if (w_fault == 2'b00)
            w_new.instr = r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (load_en)
            r_mem[load_idx] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_fetch_cnt <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            if (w_pop)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            case ({w_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0)
                        r_q0 <= w_new;
                    else
                        r_q1 <= w_new;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q0    <= r_q1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new entry replaces the head.
                    r_q0 <= w_new;
                end
                default: ;
            endcase
        end
    end

    assign rsp_instr = rsp_valid ? r_q0.instr : '0;
    assign rsp_pc    = rsp_valid ? r_q0.pc    : '0;
    assign rsp_fault = rsp_valid ? r_q0.fault : '0;
    assign fetch_cnt = r_fetch_cnt;

endmodule
